// File: rtl/mult32x32_fast.sv
// mult32x32_fast: sequential unsigned 32x32->64 multiplier.
// One 32x8 partial product per cycle, accumulated into a 64-bit product.
// Processing stops after the highest nonzero byte of b, so latency is 1..4 cycles.
module mult32x32_fast (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [63:0] product
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP0 = 3'd1,
        STEP1 = 3'd2,
        STEP2 = 3'd3,
        STEP3 = 3'd4
    } stateT;

    stateT       state_q;
    logic [31:0] aReg_q;
    logic [31:0] bReg_q;
    logic [1:0]  lastStep_q;
    logic        busy_q;
    logic [63:0] product_q;

    logic [1:0]  curStep;
    logic [7:0]  bByte;
    logic [39:0] partialProd;
    logic [63:0] shiftedPp;
    logic [63:0] product_d;
    logic [1:0]  topByteIdx;

    // Index of the highest nonzero byte of the incoming b; zero when b < 256.
    always_comb begin
        topByteIdx = 2'd0;
        if (b[31:24] != 8'd0) begin
            topByteIdx = 2'd3;
        end else if (b[23:16] != 8'd0) begin
            topByteIdx = 2'd2;
        end else if (b[15:8] != 8'd0) begin
            topByteIdx = 2'd1;
        end
    end

    // Select the byte of b for the current step and form the shifted partial product.
    always_comb begin
        curStep = 2'd0;
        bByte   = 8'd0;
        case (state_q)
            STEP0: begin
                curStep = 2'd0;
                bByte   = bReg_q[7:0];
            end
            STEP1: begin
                curStep = 2'd1;
                bByte   = bReg_q[15:8];
            end
            STEP2: begin
                curStep = 2'd2;
                bByte   = bReg_q[23:16];
            end
            STEP3: begin
                curStep = 2'd3;
                bByte   = bReg_q[31:24];
            end
            default: begin
                curStep = 2'd0;
                bByte   = 8'd0;
            end
        endcase
        partialProd = {8'd0, aReg_q} * {32'd0, bByte};
        shiftedPp   = {24'd0, partialProd} << {curStep, 3'b000};
        product_d   = product_q + shiftedPp;
    end

    // Control FSM: accept a request in IDLE, then walk the bytes of b up to the top nonzero one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            aReg_q     <= 32'd0;
            bReg_q     <= 32'd0;
            lastStep_q <= 2'd0;
            busy_q     <= 1'b0;
            product_q  <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        aReg_q     <= a;
                        bReg_q     <= b;
                        lastStep_q <= topByteIdx;
                        product_q  <= 64'd0;
                        busy_q     <= 1'b1;
                        state_q    <= STEP0;
                    end
                end
                STEP0, STEP1, STEP2, STEP3: begin
                    product_q <= product_d;
                    if (curStep == lastStep_q) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        case (state_q)
                            STEP0:   state_q <= STEP1;
                            STEP1:   state_q <= STEP2;
                            default: state_q <= STEP3;
                        endcase
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign product = product_q;

endmodule

// File: tb/tb_mult32x32_fast.sv
// Self-checking bench for mult32x32_fast using directed vectors with hand-computed products.
module tb_mult32x32_fast;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [63:0] product;

    int checks;
    int failures;

    mult32x32_fast dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .product (product)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Launch one multiply, optionally disturb start/a/b while busy, then check latency and result.
    task automatic applyStimulus(input string tag, input logic [31:0] opA, input logic [31:0] opB,
                                 input int expCycles, input logic [63:0] expProduct,
                                 input bit disturb);
        int cycles;
        @(negedge clk);
        a     = opA;
        b     = opB;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 20) begin
            cycles++;
            if (disturb && cycles == 1) begin
                start = 1'b1;
                a     = 32'h0000_0007;
                b     = 32'h0000_0009;
            end else if (disturb && cycles == 2) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput({tag, "_cycles"}, 64'(cycles), 64'(expCycles));
        checkOutput({tag, "_product"}, product, expProduct);
    endtask

    initial begin
        int cycles;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        start    = 1'b1;
        a        = 32'd3;
        b        = 32'd4;

        // Reset held for 4 cycles with start asserted: must stay idle and cleared.
        repeat (4) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_product", product, 64'd0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_busy", 64'(busy), 64'd0);

        // Main vectors.
        applyStimulus("case2", 32'd209728609, 32'd212015051, 4, 64'd44465621733294059, 1'b0);
        applyStimulus("case3", 32'd13409, 32'd6091, 2, 64'd81674219, 1'b0);
        applyStimulus("maxval", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 64'hFFFF_FFFE_0000_0001, 1'b0);
        applyStimulus("bzero", 32'd5, 32'd0, 1, 64'd0, 1'b0);
        applyStimulus("small", 32'd100, 32'd200, 1, 64'd20000, 1'b0);
        applyStimulus("byte2", 32'd2, 32'h0001_0000, 3, 64'h0000_0000_0002_0000, 1'b0);

        // Start pulse and operand changes while busy must not affect the running op.
        applyStimulus("disturb", 32'd209728609, 32'd212015051, 4, 64'd44465621733294059, 1'b1);

        // Start held high: one idle cycle between back-to-back ops.
        @(negedge clk);
        a     = 32'd13409;
        b     = 32'd6091;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("b2b_gap_busy", 64'(busy), 64'd0);
        checkOutput("b2b_first_product", product, 64'd81674219);
        @(negedge clk);
        checkOutput("b2b_restart_busy", 64'(busy), 64'd1);
        start = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 20) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput("b2b_second_product", product, 64'd81674219);

        // Reset asserted during STEP1 aborts immediately.
        @(negedge clk);
        a     = 32'd209728609;
        b     = 32'd212015051;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_product", product, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus("after_abort", 32'd209728609, 32'd212015051, 4,
                      64'd44465621733294059, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
